debounced_toggle_bank: RTL and testbench

Multi-channel push-button front end with a toggle output register per channel, for driving board LEDs and mode flags. Each raw button is synchronised, debounced and classified as a short or long press. A short press toggles the channel output on release. A long press forces the output off. A per-channel mode bit can instead select momentary (follow-the-button) behaviour.

---
 rtl/debounced_toggle_bank.sv | 100 ++++++++++
 tb/tb_debounced_toggle_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/debounced_toggle_bank.sv
// Per-channel button front end: 2-flop sync, debounce, short/long press FSM, toggle register.
// A short press toggles the channel on release, a long press forces it off; mode selects momentary output.
module debounced_toggle_bank #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  input  logic [CHANNELS-1:0] mode,
  input  logic                clr,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] short_pulse,
  output logic [CHANNELS-1:0] long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [CHANNELS-1:0] s1, s2, stable, toggle;
  logic [DW-1:0]       db_cnt   [CHANNELS];
  logic [HW-1:0]       hold_cnt [CHANNELS];
  state_t              state    [CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable      <= '0;
      toggle      <= '0;
      short_pulse <= '0;
      long_pulse  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
        state[i]    <= IDLE;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        short_pulse[i] <= 1'b0;
        long_pulse[i]  <= 1'b0;

        // Any agreeing sample restarts the count, so only an unbroken run flips the level.
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end

        case (state[i])
          IDLE: begin
            if (stable[i]) begin
              state[i]    <= PRESSED;
              hold_cnt[i] <= '0;
            end
          end
          PRESSED: begin
            if (!stable[i]) begin
              state[i]       <= IDLE;
              toggle[i]      <= ~toggle[i];
              short_pulse[i] <= 1'b1;
            end else if (hold_cnt[i] == HOLD_LAST) begin
              state[i]      <= HELD;
              toggle[i]     <= 1'b0;
              long_pulse[i] <= 1'b1;
            end else begin
              hold_cnt[i] <= hold_cnt[i] + HW'(1);
            end
          end
          HELD: begin
            if (!stable[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase

        // Clear wins over a same-edge toggle; pulses above are unaffected.
        if (clr) toggle[i] <= 1'b0;
      end
    end
  end

  assign led = (mode & stable) | (~mode & toggle);

endmodule

// File: tb/tb_debounced_toggle_bank.sv
// Scoreboarded bench for debounced_toggle_bank with CHANNELS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
module tb_debounced_toggle_bank;

  localparam int CH = 2;
  localparam int DB = 4;
  localparam int HC = 20;
  localparam int LAT = DB + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn, mode, led, short_pulse, long_pulse;
  logic          clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [CH-1:0] sp;
    logic [CH-1:0] lp;
    logic [CH-1:0] led;
    int            at;   // expected cycle, -1 = any
  } exp_t;

  exp_t q[$];

  debounced_toggle_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .clr(clr),
    .led(led), .short_pulse(short_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [CH-1:0] sp, input logic [CH-1:0] lp,
                           input logic [CH-1:0] l, input int at);
    exp_t e;
    e.sp = sp; e.lp = lp; e.led = l; e.at = at;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ((short_pulse | long_pulse) != '0)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: short %b long %b with nothing expected (cycle %0d)",
                 short_pulse, long_pulse, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (short_pulse !== e.sp || long_pulse !== e.lp || led !== e.led ||
            (e.at >= 0 && cyc != e.at)) begin
          errors++;
          $display("FAIL pulse_event: got short %b long %b led %b at cycle %0d, expected short %b long %b led %b at cycle %0d",
                   short_pulse, long_pulse, led, cyc, e.sp, e.lp, e.led, e.at);
        end
      end
    end
  end

  // Press the given channels for `hold` cycles and release; returns the release cycle.
  task automatic press(input logic [CH-1:0] ch, input int hold, output int rel);
    btn = ch;
    cycles(hold);
    btn = '0;
    rel = cyc;
  endtask

  initial begin
    int rel, c;
    rst = 1'b1; btn = '0; mode = '0; clr = 1'b0;
    cycles(3);
    chk("reset_led", led, 2'b00);
    chk("reset_pulses", short_pulse | long_pulse, 2'b00);
    rst = 1'b0;
    cycles(10);
    chk("idle_led", led, 2'b00);

    // Reset in the middle of a ch0 press (momentary so led shows the press).
    mode = 2'b01;
    btn  = 2'b01;
    cycles(10);
    chk("pre_reset_momentary_led", led, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_led", led, 2'b00);
    chk("async_reset_pulses", short_pulse | long_pulse, 2'b00);
    btn = '0; mode = '0;
    cycles(3);
    rst = 1'b0;
    cycles(12);
    chk("post_reset_led", led, 2'b00);

    // Short presses on ch0: on, then off, each seven edges after release.
    press(2'b01, 10, rel);
    expect_ev(2'b01, 2'b00, 2'b01, rel + LAT);
    cycles(12);
    chk("short1_led", led, 2'b01);
    press(2'b01, 10, rel);
    expect_ev(2'b01, 2'b00, 2'b00, rel + LAT);
    cycles(12);
    chk("short2_led", led, 2'b00);

    // Bounce: 1-cycle and 3-cycle glitches must be filtered.
    btn = 2'b01; cycles(1);
    btn = 2'b00; cycles(3);
    btn = 2'b01; cycles(3);
    btn = 2'b00; cycles(12);
    chk("bounce_led", led, 2'b00);

    // Long press from led=1: forced off once, release is silent.
    press(2'b01, 10, rel);
    expect_ev(2'b01, 2'b00, 2'b01, rel + LAT);
    cycles(12);
    chk("pre_long_led", led, 2'b01);
    expect_ev(2'b00, 2'b01, 2'b00, -1);
    press(2'b01, 40, rel);
    chk("long_held_led", led, 2'b00);
    cycles(15);
    chk("long_release_led", led, 2'b00);

    // Momentary mode follows the debounced level; toggle register still flips.
    mode = 2'b01;
    btn  = 2'b01;
    c    = cyc;
    cycles(5);
    chk("mom_rise_early", led, 2'b00);
    cycles(2);
    chk("mom_rise", led, 2'b01);
    cycles(3);
    btn = 2'b00;
    rel = cyc;
    expect_ev(2'b01, 2'b00, 2'b00, rel + LAT);
    cycles(5);
    chk("mom_fall_early", led, 2'b01);
    cycles(2);
    chk("mom_fall", led, 2'b00);
    cycles(5);
    mode = 2'b00;
    #1;
    chk("back_to_toggle_led", led, 2'b01);

    // ch1 on, then clear on the same edge as ch1's next toggle.
    press(2'b10, 10, rel);
    expect_ev(2'b10, 2'b00, 2'b11, rel + LAT);
    cycles(12);
    chk("both_on_led", led, 2'b11);
    press(2'b10, 10, rel);
    expect_ev(2'b10, 2'b00, 2'b00, rel + LAT);
    cycles(LAT - 1);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    chk("clr_led", led, 2'b00);
    cycles(8);

    // Simultaneous short presses toggle both channels together.
    press(2'b11, 10, rel);
    expect_ev(2'b11, 2'b00, 2'b11, rel + LAT);
    cycles(12);
    chk("simul_led", led, 2'b11);

    cycles(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected pulse events never seen, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
